pkt_port_arbiter: RTL and testbench

- N-input to 1-output packet multiplexer for the packet-generator output selector.
- Generalises the two-input fixed-select port mux in three ways:
  - parametrised input count;
  - register-driven mode: fixed select, round-robin polling, or halt;
  - per-input saturating packet counters.
- Switches inputs only on packet boundaries. Sits between generator/pass-through sources and each output queue.

---
 rtl/pkt_port_arbiter_if.sv | 50 +++++
 rtl/pkt_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_pkt_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_port_arbiter_if.sv
// pkt_port_arbiter_if
//   Bundles every data, handshake, control and status signal of the
//   packet port arbiter so the design and its environment connect
//   through one port.
//
//   Signals:
//     in_data/in_ctrl/in_wr   per-input word, ctrl and write strobe
//                             (channel i at [i*W +: W])
//     in_rdy                  per-input ready back to the sources
//     out_data/out_ctrl       registered output word and ctrl
//     out_wr                  output write strobe
//     out_rdy                 downstream ready
//     mode                    00 fixed select, 01 round-robin, 1x halt
//     select                  input index used in fixed mode
//     grant                   index of the current/last granted input
//     pkt_done                pulse alongside the last word of a packet
//     pkt_cnt                 per-input saturating packet counters
//
//   Modports: master = sources/downstream/control side, slave = arbiter.
interface pkt_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
);
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_INPUTS-1:0]            in_wr;
    logic [NUM_INPUTS-1:0]            in_rdy;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic [1:0]                       mode;
    logic [SEL_WIDTH-1:0]             select;
    logic [SEL_WIDTH-1:0]             grant;
    logic                             pkt_done;
    logic [NUM_INPUTS*CNT_WIDTH-1:0]  pkt_cnt;

    modport master (
        output in_data, in_ctrl, in_wr, out_rdy, mode, select,
        input  in_rdy, out_data, out_ctrl, out_wr, grant, pkt_done, pkt_cnt
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, out_rdy, mode, select,
        output in_rdy, out_data, out_ctrl, out_wr, grant, pkt_done, pkt_cnt
    );
endinterface

// File: rtl/pkt_port_arbiter.sv
// pkt_port_arbiter
//   N-input to 1-output packet multiplexer. Inputs are switched only on
//   packet boundaries; the input choice comes from a fixed select, a
//   round-robin poll, or is blocked entirely (halt). Each forwarded
//   packet bumps a saturating per-input counter.
//
//   Ports:
//     clk    clock
//     reset  asynchronous active-high reset
//     bus    pkt_port_arbiter_if.slave (see interface for signal list)
//
//   Packet framing: a packet starts with ctrl!=0 header words, then
//   ctrl==0 payload words; the first ctrl!=0 word after payload is the
//   last word and is forwarded. Accepted words appear on the output one
//   cycle later.
module pkt_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input logic             clk,
    input logic             reset,
    pkt_port_arbiter_if.slave bus
);
    // Index space covered by SEL_WIDTH; slots beyond NUM_INPUTS read as idle.
    localparam int SLOTS = 2 ** SEL_WIDTH;

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t                 state_reg;
    logic [SEL_WIDTH-1:0]   cand_reg;
    logic [SEL_WIDTH-1:0]   grant_reg;
    logic [DATA_WIDTH-1:0]  out_data_reg;
    logic [CTRL_WIDTH-1:0]  out_ctrl_reg;
    logic                   out_wr_reg;
    logic                   pkt_done_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg [NUM_INPUTS];

    logic [DATA_WIDTH-1:0]  ch_data [SLOTS];
    logic [CTRL_WIDTH-1:0]  ch_ctrl [SLOTS];
    logic                   ch_wr   [SLOTS];

    // Unpack the flat input buses into per-channel arrays.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
            if (gi < NUM_INPUTS) begin : g_real
                assign ch_data[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
                assign ch_ctrl[gi] = bus.in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH];
                assign ch_wr[gi]   = bus.in_wr[gi];
            end else begin : g_pad
                assign ch_data[gi] = '0;
                assign ch_ctrl[gi] = '0;
                assign ch_wr[gi]   = 1'b0;
            end
        end
    endgenerate

    logic                  fixed_mode;
    logic                  rr_mode;
    logic                  sel_valid;
    logic                  permit;
    logic                  rdy_any;
    logic [SEL_WIDTH-1:0]  cand_eff;
    logic                  accept;
    logic                  ctrl_nz;
    logic                  last_word;
    logic [SEL_WIDTH-1:0]  cand_inc;
    logic [SEL_WIDTH-1:0]  grant_inc;

    assign fixed_mode = (bus.mode == 2'b00);
    assign rr_mode    = (bus.mode == 2'b01);
    // An out-of-range select in fixed mode behaves like halt.
    assign sel_valid  = (int'(bus.select) < NUM_INPUTS);

    // In fixed mode the candidate tracks select directly while idle so a
    // freshly written select is honoured in the same cycle.
    assign cand_eff = (state_reg == IDLE && fixed_mode) ? bus.select : cand_reg;

    // Mid-packet the locked input keeps flowing regardless of mode.
    assign permit  = (state_reg != IDLE) || (fixed_mode && sel_valid) || rr_mode;
    assign rdy_any = bus.out_rdy && permit && !reset;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_rdy
            assign bus.in_rdy[gi] = rdy_any && (cand_eff == SEL_WIDTH'(gi));
        end
    endgenerate

    assign accept    = rdy_any && ch_wr[cand_eff];
    assign ctrl_nz   = |ch_ctrl[cand_eff];
    assign last_word = accept && (state_reg == PAY) && ctrl_nz;

    assign cand_inc  = (cand_reg == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                                : cand_reg + SEL_WIDTH'(1);
    assign grant_inc = (grant_reg == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                                 : grant_reg + SEL_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cand_reg     <= '0;
            grant_reg    <= '0;
            out_data_reg <= '0;
            out_ctrl_reg <= '0;
            out_wr_reg   <= 1'b0;
            pkt_done_reg <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            out_wr_reg   <= accept;
            pkt_done_reg <= last_word;
            // Output data only moves on an accept; otherwise it holds.
            if (accept) begin
                out_data_reg <= ch_data[cand_eff];
                out_ctrl_reg <= ch_ctrl[cand_eff];
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        grant_reg <= cand_eff;
                        cand_reg  <= cand_eff;
                        // A ctrl==0 first word is a malformed start; treat
                        // it as payload so the next ctrl!=0 word closes it.
                        state_reg <= ctrl_nz ? HDR : PAY;
                    end else if (fixed_mode && sel_valid) begin
                        cand_reg <= bus.select;
                    end else if (rr_mode) begin
                        cand_reg <= cand_inc;
                    end
                end
                HDR: begin
                    if (accept && !ctrl_nz) begin
                        state_reg <= PAY;
                    end
                end
                PAY: begin
                    if (last_word) begin
                        state_reg <= IDLE;
                        // Round-robin resumes polling just after the
                        // input that was served.
                        if (rr_mode) begin
                            cand_reg <= grant_inc;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (last_word && grant_reg == SEL_WIDTH'(i) && cnt_reg[i] != '1) begin
                    cnt_reg[i] <= cnt_reg[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.out_data = out_data_reg;
    assign bus.out_ctrl = out_ctrl_reg;
    assign bus.out_wr   = out_wr_reg;
    assign bus.grant    = grant_reg;
    assign bus.pkt_done = pkt_done_reg;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_cnt
            assign bus.pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_pkt_port_arbiter.sv
// tb_pkt_port_arbiter
//   Directed bench for pkt_port_arbiter: reset state, fixed select,
//   round-robin polling, select change mid-packet, downstream stall,
//   halt draining, counter saturation (2-bit counters), reset mid-packet.
module tb_pkt_port_arbiter;
    localparam int DW  = 64;
    localparam int CW  = 8;
    localparam int NI  = 4;
    localparam int SW  = 2;
    localparam int CNW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pkt_port_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(NI),
                          .SEL_WIDTH(SW), .CNT_WIDTH(CNW)) bus();

    pkt_port_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(NI),
                       .SEL_WIDTH(SW), .CNT_WIDTH(CNW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int src_len [NI];
    int src_idx [NI];
    int exp_ch  [$];
    int exp_idx [$];
    int chg_at;
    int stall_at;
    int stall_len;
    logic [1:0]    chg_mode;
    logic [SW-1:0] chg_sel;

    // Source word k of channel ch: 4-word packets with ctrl FF,00,00,10.
    function automatic logic [DW-1:0] wdata(input int ch, input int idx);
        return 64'hA5A5_0000_0000_0000 | (64'(ch) << 16) | 64'(idx);
    endfunction

    function automatic logic [CW-1:0] wctrl(input int idx);
        case (idx % 4)
            0:       return 8'hFF;
            3:       return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_src();
        for (int c = 0; c < NI; c++) begin
            src_len[c] = 0;
            src_idx[c] = 0;
        end
        exp_ch.delete();
        exp_idx.delete();
        chg_at    = -1;
        stall_at  = -1;
        stall_len = 0;
        bus.in_wr = '0;
    endtask

    task automatic expect_pkt(input int ch, input int first);
        for (int w = 0; w < 4; w++) begin
            exp_ch.push_back(ch);
            exp_idx.push_back(first + w);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus.in_wr[ch]            = wr;
        bus.in_ctrl[ch*CW +: CW] = c;
        bus.in_data[ch*DW +: DW] = d;
    endtask

    task automatic drive_src();
        for (int c = 0; c < NI; c++) begin
            if (src_idx[c] < src_len[c])
                set_ch(c, 1'b1, wctrl(src_idx[c]), wdata(c, src_idx[c]));
            else
                bus.in_wr[c] = 1'b0;
        end
    endtask

    // Runs the sources until n_out output words are seen or budget expires.
    task automatic run(input int n_out, input int budget);
        int got = 0;
        int cyc = 0;
        logic stalled;
        logic [NI-1:0] acc;
        while (got < n_out && cyc < budget) begin
            if (cyc == chg_at) begin
                bus.mode   = chg_mode;
                bus.select = chg_sel;
            end
            stalled     = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
            bus.out_rdy = !stalled;
            drive_src();
            #1;
            if (stalled) chk("stall_in_rdy", 64'(bus.in_rdy), 64'h0);
            acc = bus.in_rdy & bus.in_wr;
            step();
            for (int c = 0; c < NI; c++) if (acc[c]) src_idx[c]++;
            if (stalled) chk("stall_out_wr", 64'(bus.out_wr), 64'h0);
            if (bus.out_wr) begin
                if (exp_ch.size() == 0) begin
                    chk("extra_word", 64'(1), 64'(0));
                end else begin
                    int c = exp_ch.pop_front();
                    int x = exp_idx.pop_front();
                    $display("out word: ch %0d idx %0d data 0x%0h ctrl 0x%0h done %0b",
                             c, x, bus.out_data, bus.out_ctrl, bus.pkt_done);
                    chk("out_data", bus.out_data, wdata(c, x));
                    chk("out_ctrl", 64'(bus.out_ctrl), 64'(wctrl(x)));
                    chk("grant", 64'(bus.grant), 64'(c));
                    chk("pkt_done", 64'(bus.pkt_done), 64'((x % 4) == 3));
                end
                got++;
            end
            cyc++;
        end
        bus.out_rdy = 1'b1;
        chk("run_words", 64'(got), 64'(n_out));
    endtask

    initial begin
        reset       = 1'b1;
        bus.mode    = 2'b00;
        bus.select  = '0;
        bus.out_rdy = 1'b1;
        bus.in_data = '0;
        bus.in_ctrl = '0;
        clear_src();
        step();
        step();

        // Reset state: all outputs zero.
        chk("rst_out_wr",   64'(bus.out_wr),   64'h0);
        chk("rst_out_data", bus.out_data,      64'h0);
        chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'h0);
        chk("rst_grant",    64'(bus.grant),    64'h0);
        chk("rst_pkt_done", 64'(bus.pkt_done), 64'h0);
        chk("rst_pkt_cnt",  64'(bus.pkt_cnt),  64'h0);
        chk("rst_in_rdy",   64'(bus.in_rdy),   64'h0);
        reset = 1'b0;

        // Fixed select=2, 3-word packet FF,00,04.
        bus.select = 2'd2;
        set_ch(2, 1'b1, 8'hFF, 64'h1111_0000_0000_00A1);
        #1 chk("s1_rdy0", 64'(bus.in_rdy), 64'h4);
        step();
        $display("fixed w0: wr %0b data 0x%0h", bus.out_wr, bus.out_data);
        chk("s1_wr0",   64'(bus.out_wr),   64'h1);
        chk("s1_data0", bus.out_data,      64'h1111_0000_0000_00A1);
        chk("s1_ctrl0", 64'(bus.out_ctrl), 64'hFF);
        chk("s1_done0", 64'(bus.pkt_done), 64'h0);
        chk("s1_grant", 64'(bus.grant),    64'h2);
        set_ch(2, 1'b1, 8'h00, 64'h1111_0000_0000_00A2);
        #1 chk("s1_rdy1", 64'(bus.in_rdy), 64'h4);
        step();
        $display("fixed w1: wr %0b data 0x%0h", bus.out_wr, bus.out_data);
        chk("s1_wr1",   64'(bus.out_wr),   64'h1);
        chk("s1_data1", bus.out_data,      64'h1111_0000_0000_00A2);
        chk("s1_ctrl1", 64'(bus.out_ctrl), 64'h00);
        chk("s1_done1", 64'(bus.pkt_done), 64'h0);
        set_ch(2, 1'b1, 8'h04, 64'h1111_0000_0000_00A3);
        #1 chk("s1_rdy2", 64'(bus.in_rdy), 64'h4);
        step();
        $display("fixed w2: wr %0b data 0x%0h done %0b", bus.out_wr, bus.out_data, bus.pkt_done);
        chk("s1_wr2",   64'(bus.out_wr),   64'h1);
        chk("s1_data2", bus.out_data,      64'h1111_0000_0000_00A3);
        chk("s1_ctrl2", 64'(bus.out_ctrl), 64'h04);
        chk("s1_done2", 64'(bus.pkt_done), 64'h1);
        chk("s1_cnt",   64'(bus.pkt_cnt),  64'h10);
        bus.in_wr = '0;
        step();
        chk("s1_idle_wr",   64'(bus.out_wr),   64'h0);
        chk("s1_idle_done", 64'(bus.pkt_done), 64'h0);
        chk("s1_hold_data", bus.out_data,      64'h1111_0000_0000_00A3);

        // Round-robin: inputs 0 and 3, two packets each -> 0,3,0,3.
        clear_src();
        do_reset();
        bus.mode = 2'b01;
        src_len[0] = 8;
        src_len[3] = 8;
        expect_pkt(0, 0);
        expect_pkt(3, 0);
        expect_pkt(0, 4);
        expect_pkt(3, 4);
        run(16, 80);
        chk("rr_cnt", 64'(bus.pkt_cnt), 64'h82);

        // Select 1 -> 0 during input-1 payload.
        clear_src();
        do_reset();
        bus.mode   = 2'b00;
        bus.select = 2'd1;
        src_len[1] = 4;
        src_len[0] = 4;
        expect_pkt(1, 0);
        expect_pkt(0, 0);
        chg_at   = 2;
        chg_mode = 2'b00;
        chg_sel  = 2'd0;
        run(8, 40);
        chk("sel_cnt", 64'(bus.pkt_cnt), 64'h05);

        // out_rdy low for 5 cycles mid-payload.
        clear_src();
        do_reset();
        bus.mode   = 2'b00;
        bus.select = 2'd3;
        src_len[3] = 8;
        expect_pkt(3, 0);
        expect_pkt(3, 4);
        stall_at  = 2;
        stall_len = 5;
        run(8, 60);
        chk("stall_cnt", 64'(bus.pkt_cnt), 64'h80);

        // Halt asserted mid-packet: packet drains, then nothing moves.
        clear_src();
        do_reset();
        bus.mode   = 2'b01;
        src_len[1] = 4;
        src_len[2] = 8;
        expect_pkt(1, 0);
        chg_at   = 3;
        chg_mode = 2'b10;
        chg_sel  = 2'd0;
        run(4, 40);
        chk("halt_cnt", 64'(bus.pkt_cnt), 64'h04);
        for (int k = 0; k < 20; k++) begin
            drive_src();
            #1 chk("halt_in_rdy", 64'(bus.in_rdy), 64'h0);
            step();
            chk("halt_out_wr", 64'(bus.out_wr), 64'h0);
        end
        $display("halt: 20 blocked cycles observed");

        // 2-bit counter saturation: 5 packets on input 1.
        clear_src();
        do_reset();
        bus.mode   = 2'b00;
        bus.select = 2'd1;
        src_len[1] = 20;
        for (int p = 0; p < 5; p++) expect_pkt(1, 4 * p);
        run(20, 80);
        chk("sat_cnt", 64'(bus.pkt_cnt), 64'h0C);

        // Reset mid-packet, then a clean packet.
        clear_src();
        bus.select = 2'd2;
        src_len[2] = 4;
        expect_pkt(2, 0);
        run(2, 20);
        reset = 1'b1;
        #1;
        $display("async reset: wr %0b grant %0d cnt 0x%0h", bus.out_wr, bus.grant, bus.pkt_cnt);
        chk("arst_out_wr",   64'(bus.out_wr),   64'h0);
        chk("arst_grant",    64'(bus.grant),    64'h0);
        chk("arst_pkt_cnt",  64'(bus.pkt_cnt),  64'h0);
        chk("arst_pkt_done", 64'(bus.pkt_done), 64'h0);
        clear_src();
        step();
        reset = 1'b0;
        src_len[2] = 4;
        expect_pkt(2, 0);
        run(4, 20);
        chk("arst_after_cnt", 64'(bus.pkt_cnt), 64'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
